// File: rtl/pes_elevator_call_dispatcher.sv
// SCAN-policy call dispatcher feeding pes_elevator: latches call buttons,
// issues one one-hot target at a time, dwells after each serve or timeout.
module pes_elevator_call_dispatcher #(
    parameter int unsigned N_FLOORS       = 8,
    parameter int unsigned DWELL_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call_buttons,
    input  logic [N_FLOORS-1:0] cur_floor,
    input  logic                complete,
    input  logic                door_alert,
    input  logic                weight_alert,
    output logic [N_FLOORS-1:0] request_floor,
    output logic                req_valid,
    output logic [N_FLOORS-1:0] pending,
    output logic                sweep_up,
    output logic                busy,
    output logic                fault
);

    localparam int unsigned IW  = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned DCW = $clog2(DWELL_CYCLES) + 1;
    localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [DCW-1:0] D_LOAD = DCW'(DWELL_CYCLES);
    localparam logic [N_FLOORS-1:0] ONE = {{(N_FLOORS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DWELL
    } state_t;

    state_t              state;
    logic                complete_q;
    logic [TCW-1:0]      tcnt;
    logic [DCW-1:0]      dcnt;

    logic                cedge;
    logic                timeout_hit;
    logic                cur_valid;
    logic [IW-1:0]       cur_idx;
    logic [IW-1:0]       ge_idx;
    logic [IW-1:0]       gt_idx;
    logic [IW-1:0]       lt_idx;
    logic [IW-1:0]       le_idx;
    logic                ge_found;
    logic                le_found;
    logic [IW-1:0]       pick_idx;
    logic                pick_flip;
    logic [N_FLOORS-1:0] clr;

    assign cedge       = complete & ~complete_q;
    assign timeout_hit = (tcnt == T_LAST);
    assign cur_valid   = (cur_floor != '0) &&
                         ((cur_floor & (cur_floor - ONE)) == '0);
    assign clr         = ((state == WAIT) && (cedge || timeout_hit)) ? request_floor : '0;

    always_comb begin
        cur_idx  = '0;
        ge_idx   = '0;
        gt_idx   = '0;
        lt_idx   = '0;
        le_idx   = '0;
        ge_found = 1'b0;
        le_found = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (cur_floor[i]) cur_idx = IW'(i);
        end
        // Bottom-up walk: last hit is the highest floor at/below the car.
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending[i]) begin
                if (IW'(i) < cur_idx) lt_idx = IW'(i);
                if (IW'(i) <= cur_idx) begin
                    le_idx   = IW'(i);
                    le_found = 1'b1;
                end
            end
        end
        // Top-down walk: last hit is the lowest floor at/above the car.
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending[N_FLOORS-1-i]) begin
                if (IW'(N_FLOORS-1-i) > cur_idx) gt_idx = IW'(N_FLOORS-1-i);
                if (IW'(N_FLOORS-1-i) >= cur_idx) begin
                    ge_idx   = IW'(N_FLOORS-1-i);
                    ge_found = 1'b1;
                end
            end
        end
        pick_idx  = '0;
        pick_flip = 1'b0;
        if (sweep_up) begin
            if (ge_found) begin
                pick_idx = ge_idx;
            end else begin
                pick_idx  = lt_idx;
                pick_flip = 1'b1;
            end
        end else begin
            if (le_found) begin
                pick_idx = le_idx;
            end else begin
                pick_idx  = gt_idx;
                pick_flip = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            request_floor <= '0;
            req_valid     <= 1'b0;
            pending       <= '0;
            sweep_up      <= 1'b1;
            busy          <= 1'b0;
            fault         <= 1'b0;
            complete_q    <= 1'b0;
            tcnt          <= '0;
            dcnt          <= '0;
        end else begin
            complete_q <= complete;
            pending    <= (pending & ~clr) | call_buttons;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if ((pending != '0) && cur_valid) begin
                        request_floor <= ONE << pick_idx;
                        req_valid     <= 1'b1;
                        busy          <= 1'b1;
                        tcnt          <= '0;
                        state         <= WAIT;
                        if (pick_flip) sweep_up <= ~sweep_up;
                    end
                end
                WAIT: begin
                    if (cedge) begin
                        request_floor <= '0;
                        req_valid     <= 1'b0;
                        dcnt          <= D_LOAD;
                        state         <= DWELL;
                    end else if (timeout_hit) begin
                        fault         <= 1'b1;
                        request_floor <= '0;
                        req_valid     <= 1'b0;
                        dcnt          <= D_LOAD;
                        state         <= DWELL;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end
                DWELL: begin
                    if (!(door_alert || weight_alert)) begin
                        if (dcnt <= DCW'(1)) begin
                            dcnt  <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            dcnt <= dcnt - DCW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pes_elevator_call_dispatcher.sv
// Directed scenarios plus a randomized run checked against a distance-based
// SCAN reference model of the dispatcher.
module tb_pes_elevator_call_dispatcher;

    localparam int NF = 8;
    localparam int DW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] call_buttons = '0;
    logic [NF-1:0] cur_floor = '0;
    logic          complete = 1'b0;
    logic          door_alert = 1'b0;
    logic          weight_alert = 1'b0;
    logic [NF-1:0] request_floor;
    logic          req_valid;
    logic [NF-1:0] pending;
    logic          sweep_up;
    logic          busy;
    logic          fault;

    int vectors = 0;
    int miscompares = 0;

    pes_elevator_call_dispatcher #(
        .N_FLOORS(NF),
        .DWELL_CYCLES(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .call_buttons(call_buttons),
        .cur_floor(cur_floor),
        .complete(complete),
        .door_alert(door_alert),
        .weight_alert(weight_alert),
        .request_floor(request_floor),
        .req_valid(req_valid),
        .pending(pending),
        .sweep_up(sweep_up),
        .busy(busy),
        .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; call_buttons = '0; complete = 1'b0;
        door_alert = 1'b0; weight_alert = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit [7:0] m_pend;
    bit       m_up;
    int       m_phase;   // 0 idle, 1 waiting on controller, 2 dwelling
    int       m_tgt;
    int       m_wait;
    int       m_dwell;
    bit       m_cq;
    bit       m_fault;

    // Nearest pending floor walking outward from c in direction dir.
    function automatic int nearest(input bit [7:0] p, input int c, input int dir, input bit incl);
        for (int d = (incl ? 0 : 1); d < NF; d++) begin
            int f;
            f = c + dir * d;
            if (f >= 0 && f < NF && p[f]) return f;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit [7:0] btn, input bit [7:0] cur,
                              input bit comp, input bit alert);
        bit       ce;
        bit [7:0] clr;
        int       c;
        int       t;
        if (rst) begin
            m_pend = 0; m_up = 1; m_phase = 0; m_tgt = -1;
            m_wait = 0; m_dwell = 0; m_cq = 0; m_fault = 0;
            return;
        end
        ce = comp && !m_cq;
        clr = 0;
        m_fault = 0;
        if (m_phase == 0) begin
            if (m_pend != 0 && $countones(cur) == 1) begin
                c = 0;
                for (int k = 0; k < NF; k++) if (cur[k]) c = k;
                if (m_up) begin
                    t = nearest(m_pend, c, 1, 1);
                    if (t < 0) begin m_up = 0; t = nearest(m_pend, c, -1, 0); end
                end else begin
                    t = nearest(m_pend, c, -1, 1);
                    if (t < 0) begin m_up = 1; t = nearest(m_pend, c, 1, 0); end
                end
                m_tgt = t; m_phase = 1; m_wait = 0;
            end
        end else if (m_phase == 1) begin
            if (ce) begin
                clr = 8'd1 << m_tgt; m_tgt = -1; m_phase = 2; m_dwell = DW;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_fault = 1; clr = 8'd1 << m_tgt; m_tgt = -1; m_phase = 2; m_dwell = DW;
                end
            end
        end else begin
            if (!alert) begin
                m_dwell--;
                if (m_dwell <= 0) m_phase = 0;
            end
        end
        m_pend = (m_pend & ~clr) | btn;
        m_cq = comp;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({request_floor, req_valid, pending, sweep_up, busy, fault} !== {8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got req=%h v=%b pend=%h up=%b busy=%b fault=%b, want 00 0 00 1 0 0",
                     request_floor, req_valid, pending, sweep_up, busy, fault);
        end
        cur_floor = 8'h01; call_buttons = 8'h0A;
        tick();
        call_buttons = '0;
        tick();
        vectors++;
        if (req_valid !== 1'b1 || pending !== 8'h0A) begin
            miscompares++;
            $display("FAIL reset_setup: got v=%b pend=%h, want 1 0a", req_valid, pending);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({request_floor, req_valid, pending, sweep_up, busy} !== {8'h00, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_midwait: got req=%h v=%b pend=%h up=%b busy=%b, want 00 0 00 1 0",
                     request_floor, req_valid, pending, sweep_up, busy);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_call();
        int n;
        do_reset();
        cur_floor = 8'h80; call_buttons = 8'h01;
        tick();
        call_buttons = '0;
        vectors++;
        if (pending !== 8'h01 || req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pending: got pend=%h v=%b, want 01 0", pending, req_valid);
        end
        tick();
        vectors++;
        if (request_floor !== 8'h01 || req_valid !== 1'b1 || sweep_up !== 1'b0) begin
            miscompares++;
            $display("FAIL single_issue: got req=%h v=%b up=%b, want 01 1 0", request_floor, req_valid, sweep_up);
        end
        complete = 1'b1;
        tick();
        vectors++;
        if (pending !== 8'h00 || req_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_serve: got pend=%h v=%b busy=%b, want 00 0 1", pending, req_valid, busy);
        end
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        vectors++;
        if (n !== DW) begin
            miscompares++;
            $display("FAIL single_dwell: got %0d dwell cycles, want %0d", n, DW);
        end
        complete = 1'b0;
        tick();
    endtask

    task automatic test_scan_order();
        bit [7:0] order [3];
        int n;
        order[0] = 8'h10; order[1] = 8'h80; order[2] = 8'h01;
        do_reset();
        cur_floor = 8'h04; call_buttons = 8'h91;
        tick();
        call_buttons = '0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!req_valid && n < 40) begin tick(); n++; end
            vectors++;
            if (req_valid !== 1'b1 || request_floor !== order[k]) begin
                miscompares++;
                $display("FAIL scan_target%0d: got req=%h v=%b, want %h 1", k, request_floor, req_valid, order[k]);
            end
            complete = 1'b1;
            tick();
            complete = 1'b0;
        end
        vectors++;
        if (sweep_up !== 1'b0 || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL scan_final: got up=%b pend=%h, want 0 00", sweep_up, pending);
        end
    endtask

    task automatic test_timeout();
        int nf;
        int at_k;
        bit [7:0] pend_at;
        bit rv_at;
        bit busy_at;
        do_reset();
        cur_floor = 8'h01; call_buttons = 8'h02;
        tick();
        call_buttons = '0;
        tick();
        vectors++;
        if (req_valid !== 1'b1 || request_floor !== 8'h02) begin
            miscompares++;
            $display("FAIL timeout_issue: got req=%h v=%b, want 02 1", request_floor, req_valid);
        end
        nf = 0; at_k = -1; pend_at = 8'hFF; rv_at = 1'b1; busy_at = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (fault === 1'b1) begin
                nf++;
                at_k = k; pend_at = pending; rv_at = req_valid; busy_at = busy;
            end
        end
        vectors++;
        if (nf !== 1 || at_k !== TO) begin
            miscompares++;
            $display("FAIL timeout_pulse: got %0d pulses at wait cycle %0d, want 1 at %0d", nf, at_k, TO);
        end
        vectors++;
        if (pend_at !== 8'h00 || rv_at !== 1'b0 || busy_at !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_state: got pend=%h v=%b busy=%b, want 00 0 1", pend_at, rv_at, busy_at);
        end
    endtask

    task automatic test_alerts();
        int n;
        bit held;
        do_reset();
        cur_floor = 8'h01; call_buttons = 8'h06;
        tick();
        call_buttons = '0;
        tick();
        vectors++;
        if (request_floor !== 8'h02) begin
            miscompares++;
            $display("FAIL alert_issue: got req=%h, want 02", request_floor);
        end
        complete = 1'b1; door_alert = 1'b1;
        tick();
        n = 0;
        while (busy && n < 60) begin
            tick(); n++;
            if (n == 10) door_alert = 1'b0;
        end
        vectors++;
        if (n !== DW + 10) begin
            miscompares++;
            $display("FAIL alert_dwell: got %0d dwell cycles, want %0d", n, DW + 10);
        end
        tick();
        vectors++;
        if (request_floor !== 8'h04 || req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL alert_next_issue: got req=%h v=%b, want 04 1", request_floor, req_valid);
        end
        held = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req_valid !== 1'b1 || request_floor !== 8'h04) held = 1'b0;
        end
        vectors++;
        if (held !== 1'b1) begin
            miscompares++;
            $display("FAIL alert_no_spurious: got req=%h v=%b, want 04 1 held", request_floor, req_valid);
        end
        complete = 1'b0;
        tick();
        complete = 1'b1;
        tick();
        vectors++;
        if (req_valid !== 1'b0 || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL alert_serve: got v=%b pend=%h, want 0 00", req_valid, pending);
        end
        complete = 1'b0;
    endtask

    task automatic test_collision();
        int n;
        do_reset();
        cur_floor = 8'h01; call_buttons = 8'h08;
        tick();
        call_buttons = '0;
        tick();
        vectors++;
        if (request_floor !== 8'h08) begin
            miscompares++;
            $display("FAIL collide_issue: got req=%h, want 08", request_floor);
        end
        complete = 1'b1; call_buttons = 8'h08;
        tick();
        complete = 1'b0; call_buttons = '0;
        vectors++;
        if (pending !== 8'h08 || req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_pending: got pend=%h v=%b, want 08 0", pending, req_valid);
        end
        n = 0;
        while (!req_valid && n < 40) begin tick(); n++; end
        vectors++;
        if (req_valid !== 1'b1 || request_floor !== 8'h08) begin
            miscompares++;
            $display("FAIL collide_reissue: got req=%h v=%b, want 08 1", request_floor, req_valid);
        end
        complete = 1'b1;
        tick();
        complete = 1'b0;
    endtask

    task automatic test_random();
        bit [7:0] exp_req;
        bit       rst;
        bit [7:0] b;
        bit [7:0] c;
        int       r;
        reset = 1'b1;
        model_step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            b = 8'h00;
            if ($urandom_range(0, 5) == 0) b = 8'd1 << $urandom_range(0, 7);
            r = $urandom_range(0, 15);
            if (r == 0) c = 8'h00;
            else if (r == 1) c = 8'($urandom_range(0, 255));
            else c = 8'd1 << $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) complete = ~complete;
            door_alert   = ($urandom_range(0, 9) == 0);
            weight_alert = ($urandom_range(0, 9) == 0);
            reset = rst; call_buttons = b; cur_floor = c;
            model_step(rst, b, c, complete, door_alert | weight_alert);
            tick();
            exp_req = (m_phase == 1) ? (8'd1 << m_tgt) : 8'h00;
            vectors++;
            if (request_floor !== exp_req) begin
                miscompares++;
                $display("FAIL rand_request cyc %0d: got %h, want %h", cyc, request_floor, exp_req);
            end
            vectors++;
            if (req_valid !== (m_phase == 1)) begin
                miscompares++;
                $display("FAIL rand_valid cyc %0d: got %b, want %b", cyc, req_valid, (m_phase == 1));
            end
            vectors++;
            if (pending !== m_pend) begin
                miscompares++;
                $display("FAIL rand_pending cyc %0d: got %h, want %h", cyc, pending, m_pend);
            end
            vectors++;
            if (sweep_up !== m_up) begin
                miscompares++;
                $display("FAIL rand_sweep cyc %0d: got %b, want %b", cyc, sweep_up, m_up);
            end
            vectors++;
            if (busy !== (m_phase != 0)) begin
                miscompares++;
                $display("FAIL rand_busy cyc %0d: got %b, want %b", cyc, busy, (m_phase != 0));
            end
            vectors++;
            if (fault !== m_fault) begin
                miscompares++;
                $display("FAIL rand_fault cyc %0d: got %b, want %b", cyc, fault, m_fault);
            end
        end
        reset = 1'b0; call_buttons = '0; complete = 1'b0;
        door_alert = 1'b0; weight_alert = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan_order();
        test_timeout();
        test_alerts();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pes_elevator_call_dispatcher.md
Name: pes_elevator_call_dispatcher

Overview:
Request-side counterpart of pes_elevator. It collects hall/cabin call buttons into a pending-call register and picks the next target floor with a SCAN (sweep) policy. It drives that floor as a one-hot request_floor to the controller and holds it until the controller signals complete, then dwells before issuing the next call. It sits between the button-input logic and pes_elevator, consuming the controller's out_current_floor, complete, door_alert and weight_alert.

Parameters:
N_FLOORS, 8, number of floors; width of all floor vectors (one-hot, bit 0 = ground).
DWELL_CYCLES, 4, cycles spent in DWELL after a call is served, before the next issue.
TIMEOUT_CYCLES, 64, maximum WAIT cycles without a complete edge before the call is abandoned.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
call_buttons  in  N_FLOORS  button bits, any number set per cycle, sampled every cycle.
cur_floor  in  N_FLOORS  one-hot current floor, driven from the controller's out_current_floor.
complete  in  1  controller arrival indication (level); only its rising edge is used.
door_alert  in  1  controller door alert; freezes the dwell count.
weight_alert  in  1  controller weight alert; freezes the dwell count.
request_floor  out  N_FLOORS  one-hot target to the controller; all zeros when no request is active.
req_valid  out  1  high while request_floor holds an outstanding target.
pending  out  N_FLOORS  registered pending-call bitmap.
sweep_up  out  1  current sweep direction: 1 = up, 0 = down.
busy  out  1  high in WAIT or DWELL.
fault  out  1  one-cycle pulse when a call times out.

Behaviour:
- Reset values: request_floor=0, req_valid=0, pending=0, sweep_up=1, busy=0, fault=0, state=IDLE, complete_q=0, all counters=0.
- Reset asserted mid-operation discards the outstanding request and all pending calls on the next edge.
- pending update: pending <= (pending & ~clr) | call_buttons.
  - clr is the target bit on a serve or timeout, else 0.
  - A set in the same cycle as a clear wins, so the bit stays pending.
  - A press is visible on pending one cycle later.
- complete edge: cedge = complete & ~complete_q; complete_q <= complete every cycle.
- State IDLE:
  - If pending==0, or cur_floor is not exactly one-hot (zero or multi-hot), remain in IDLE with outputs idle.
  - Otherwise select a target:
    - sweep_up=1: nearest pending index >= cur. If none, set sweep_up<=0 and take the nearest pending index < cur.
    - sweep_up=0: nearest pending index <= cur. If none, set sweep_up<=1 and take the nearest pending index > cur.
  - Register request_floor=target (one-hot), req_valid=1, clear the timeout counter, go to WAIT.
  - Latency: press at cycle t, pending at t+1, request visible at t+2.
- State WAIT:
  - request_floor and req_valid are held stable; new calls only accumulate in pending.
  - On cedge: clear the target pending bit, request_floor=0, req_valid=0, load the dwell counter with DWELL_CYCLES, go to DWELL.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 without cedge:
    - pulse fault for one cycle;
    - clear the target pending bit and drop the request;
    - go to DWELL.
  - cedge and timeout in the same cycle: cedge wins and fault stays 0.
- State DWELL:
  - The counter decrements each cycle unless door_alert or weight_alert is high (then it holds).
  - At 0, go to IDLE. busy=1 throughout.
  - A complete level still high from WAIT never re-triggers a serve, because only edges are used.
- busy = (state==WAIT) | (state==DWELL).
- Counter widths are clog2 of the respective parameter plus 1; no wrap is possible because counters saturate by state exit.

Test Plan:
- Reset: assert reset 2 cycles mid-WAIT with pending=0x0A -> next edge request_floor=0x00, req_valid=0, pending=0x00, sweep_up=1, state IDLE.
- Single call: cur_floor=0x80, call_buttons=0x01 for 1 cycle -> pending=0x01 at t+1; request_floor=0x01, req_valid=1, sweep_up=0 at t+2; complete rises -> pending=0x00, req_valid=0, IDLE after 4 dwell cycles.
- SCAN order: cur_floor=0x04, sweep_up=1, pending=0x91 -> targets issued in order 0x10, 0x80, then (direction flips) 0x01, each after a complete edge.
- Timeout: call 0x02 with complete held 0 -> fault pulses exactly once after 64 WAIT cycles, pending bit 1 cleared, DWELL entered.
- Alerts: door_alert=1 for 10 cycles during DWELL -> DWELL lasts 14 cycles; complete left high through DWELL -> no spurious serve of the next target.
- Collision: call_buttons=0x08 in the same cycle as the complete edge for target 0x08 -> pending bit 3 remains set and is re-issued after DWELL.
